// File: rtl/ttl191_divider_ctrl.sv
// Controller for a chain of 74LS191 up/down counters used as a programmable divider.
// Optional Q/RCO_n consistency checker enabled by defining TTL191_CHECK_EN.
module ttl191_divider_ctrl #(
    parameter int STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic                  START,
    input  logic                  STOP,
    input  logic [4*STAGES-1:0]   PRESET,
    input  logic                  DIR,
    input  logic                  CONT,
    input  logic                  RCO_n,
    input  logic [4*STAGES-1:0]   Q,
    output logic [4*STAGES-1:0]   D,
    output logic                  LOAD_n,
    output logic                  CTEN_n,
    output logic                  DOWN_UP_n,
    output logic                  BUSY,
    output logic                  TC_PULSE,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [1:0]            dbg_state
);

    localparam int W = 4 * STAGES;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COUNT  = 2'd2,
        ST_RELOAD = 2'd3
    } state_t;

    // START and STOP are level requests sampled on each rising edge, with no
    // ready handshake: START is accepted only in IDLE, STOP is accepted in any
    // state and outranks both START and RCO_n.
    state_t         state_q, state_d;
    logic [W-1:0]   d_q, d_d;
    logic           down_up_n_q, down_up_n_d;
    logic           cont_q, cont_d;
    logic           load_n_q, load_n_d;
    logic           cten_n_q, cten_n_d;
    logic           busy_q, busy_d;
    logic           tc_pulse_q, tc_pulse_d;
    logic           done_q, done_d;

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        down_up_n_d = down_up_n_q;
        cont_d      = cont_q;
        tc_pulse_d  = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START && !STOP) begin
                    d_d         = PRESET;
                    down_up_n_d = DIR;
                    cont_d      = CONT;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD, ST_RELOAD: begin
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (!RCO_n) begin
                    tc_pulse_d = 1'b1;
                    if (cont_q) begin
                        state_d = ST_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        if (STOP) begin
            state_d    = ST_IDLE;
            tc_pulse_d = 1'b0;
            done_d     = 1'b0;
        end

        // Chain controls are decoded from the next state so they are registered
        // and line up with the state they belong to.
        load_n_d = !((state_d == ST_LOAD) || (state_d == ST_RELOAD));
        cten_n_d = (state_d != ST_COUNT);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            d_q         <= '0;
            down_up_n_q <= 1'b0;
            cont_q      <= 1'b0;
            load_n_q    <= 1'b1;
            cten_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            tc_pulse_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            down_up_n_q <= down_up_n_d;
            cont_q      <= cont_d;
            load_n_q    <= load_n_d;
            cten_n_q    <= cten_n_d;
            busy_q      <= busy_d;
            tc_pulse_q  <= tc_pulse_d;
            done_q      <= done_d;
        end
    end

`ifdef TTL191_CHECK_EN
    logic [W-1:0] shadow_q, shadow_d;
    logic         error_q, error_d;
    logic         shadow_term;

    // The shadow tracks what the chain should hold before each COUNT edge.
    always_comb begin
        shadow_d    = shadow_q;
        error_d     = error_q;
        shadow_term = 1'b0;
        unique case (state_q)
            ST_LOAD, ST_RELOAD: begin
                shadow_d = d_q;
            end
            ST_COUNT: begin
                shadow_term = down_up_n_q ? (shadow_q == '0) : (shadow_q == '1);
                if ((Q != shadow_q) || ((!RCO_n) != shadow_term)) begin
                    error_d = 1'b1;
                end
                shadow_d = down_up_n_q ? (shadow_q - W'(1)) : (shadow_q + W'(1));
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            shadow_q <= '0;
            error_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            error_q  <= error_d;
        end
    end

    assign ERROR = error_q;
`else
    logic unused_q_bits;
    assign unused_q_bits = ^Q;
    assign ERROR = 1'b0;
`endif

    assign D         = d_q;
    assign LOAD_n    = load_n_q;
    assign CTEN_n    = cten_n_q;
    assign DOWN_UP_n = down_up_n_q;
    assign BUSY      = busy_q;
    assign TC_PULSE  = tc_pulse_q;
    assign DONE      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ttl191_divider_ctrl.sv
// Directed bench for ttl191_divider_ctrl: one 4-bit and one 8-bit controller,
// each driving a behavioural 74LS191 chain model.
module tb_ttl191_divider_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef TTL191_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // ---------------- instance 1: STAGES=1 ----------------
    logic       start1, stop1, dir1, cont1, rco1_n;
    logic [3:0] preset1, q1, d1;
    logic       load1_n, cten1_n, dnup1, busy1, tc1, done1, err1;
    logic [1:0] st1;
    logic [3:0] cnt1 = '0;
    logic [3:0] q1_flip;
    logic       rco1_force;

    ttl191_divider_ctrl #(.STAGES(1)) u1 (
        .CLK(clk), .RESET_n(rst_n), .START(start1), .STOP(stop1),
        .PRESET(preset1), .DIR(dir1), .CONT(cont1), .RCO_n(rco1_n), .Q(q1),
        .D(d1), .LOAD_n(load1_n), .CTEN_n(cten1_n), .DOWN_UP_n(dnup1),
        .BUSY(busy1), .TC_PULSE(tc1), .DONE(done1), .ERROR(err1), .dbg_state(st1)
    );

    always @(posedge clk) begin
        if (!load1_n) cnt1 <= d1;
        else if (!cten1_n) cnt1 <= dnup1 ? cnt1 - 4'd1 : cnt1 + 4'd1;
    end
    assign rco1_n = !((!cten1_n && (dnup1 ? (cnt1 == 4'h0) : (cnt1 == 4'hF))) || rco1_force);
    assign q1 = cnt1 ^ q1_flip;

    // ---------------- instance 2: STAGES=2 ----------------
    logic       start2, stop2, dir2, cont2, rco2_n;
    logic [7:0] preset2, q2, d2;
    logic       load2_n, cten2_n, dnup2, busy2, tc2, done2, err2;
    logic [1:0] st2;
    logic [7:0] cnt2 = '0;

    ttl191_divider_ctrl #(.STAGES(2)) u2 (
        .CLK(clk), .RESET_n(rst_n), .START(start2), .STOP(stop2),
        .PRESET(preset2), .DIR(dir2), .CONT(cont2), .RCO_n(rco2_n), .Q(q2),
        .D(d2), .LOAD_n(load2_n), .CTEN_n(cten2_n), .DOWN_UP_n(dnup2),
        .BUSY(busy2), .TC_PULSE(tc2), .DONE(done2), .ERROR(err2), .dbg_state(st2)
    );

    always @(posedge clk) begin
        if (!load2_n) cnt2 <= d2;
        else if (!cten2_n) cnt2 <= dnup2 ? cnt2 - 8'd1 : cnt2 + 8'd1;
    end
    assign rco2_n = !(!cten2_n && (dnup2 ? (cnt2 == 8'h00) : (cnt2 == 8'hFF)));
    assign q2 = cnt2;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 0; stop1 = 0; dir1 = 0; cont1 = 0; preset1 = '0;
        start2 = 0; stop2 = 0; dir2 = 0; cont2 = 0; preset2 = '0;
        q1_flip = '0; rco1_force = 0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state of both instances
        check("rst_state1", st1, 0);   check("rst_load1", load1_n, 1);
        check("rst_cten1", cten1_n, 1); check("rst_dnup1", dnup1, 0);
        check("rst_d1", d1, 0);        check("rst_busy1", busy1, 0);
        check("rst_tc1", tc1, 0);      check("rst_done1", done1, 0);
        check("rst_err1", err1, 0);
        check("rst_state2", st2, 0);   check("rst_load2", load2_n, 1);
        check("rst_cten2", cten2_n, 1); check("rst_d2", d2, 0);
        check("rst_busy2", busy2, 0);  check("rst_err2", err2, 0);

        // One-shot up, PRESET=12 on 4 bits: TC sampled at e5
        preset1 = 4'd12; dir1 = 0; cont1 = 0; start1 = 1;
        tick(); // e0
        start1 = 0;
        check("os_load_e0", load1_n, 0); check("os_cten_e0", cten1_n, 1);
        check("os_busy_e0", busy1, 1);   check("os_d_e0", d1, 12);
        check("os_dir_e0", dnup1, 0);    check("os_state_e0", st1, 1);
        tick(); // e1
        check("os_load_e1", load1_n, 1); check("os_cten_e1", cten1_n, 0);
        check("os_state_e1", st1, 2);
        for (int e = 2; e <= 4; e++) begin
            tick();
            check("os_tc_pre", tc1, 0);
            check("os_busy_pre", busy1, 1);
        end
        tick(); // e5
        check("os_tc_e5", tc1, 1);     check("os_done_e5", done1, 1);
        check("os_busy_e5", busy1, 0); check("os_cten_e5", cten1_n, 1);
        tick(); // e6
        check("os_tc_e6", tc1, 0);     check("os_done_e6", done1, 0);

        // Continuous down, PRESET=3: TC every 5 edges, RELOAD right after each TC;
        // STOP coinciding with RCO_n low at e20 suppresses the TC
        preset1 = 4'd3; dir1 = 1; cont1 = 1; start1 = 1;
        tick(); // e0
        start1 = 0;
        check("cd_dir", dnup1, 1); check("cd_load_e0", load1_n, 0);
        for (int e = 1; e <= 19; e++) begin
            tick();
            check("cd_tc", tc1, ((e % 5) == 0) ? 1 : 0);
            check("cd_load", load1_n, ((e % 5) == 0) ? 0 : 1);
            check("cd_busy", busy1, 1);
        end
        stop1 = 1;
        tick(); // e20
        stop1 = 0;
        check("cd_stop_tc", tc1, 0);     check("cd_stop_done", done1, 0);
        check("cd_stop_busy", busy1, 0); check("cd_stop_cten", cten1_n, 1);
        check("cd_stop_state", st1, 0);

        // 8-bit, PRESET=0xFF up: TC at e2, chain then held at 0x00
        preset2 = 8'hFF; dir2 = 0; cont2 = 0; start2 = 1;
        tick(); // e0
        start2 = 0;
        tick(); // e1
        check("ff_tc_e1", tc2, 0); check("ff_cten_e1", cten2_n, 0);
        tick(); // e2
        check("ff_tc_e2", tc2, 1); check("ff_done_e2", done2, 1);
        check("ff_busy_e2", busy2, 0); check("ff_cten_e2", cten2_n, 1);
        tick();
        tick();
        check("ff_hold", cnt2, 8'h00);
        check("ff_tc_after", tc2, 0);

        // 8-bit, PRESET=0 down: TC at e2
        preset2 = 8'h00; dir2 = 1; cont2 = 0; start2 = 1;
        tick(); // e0
        start2 = 0;
        check("z_dir", dnup2, 1); check("z_d", d2, 0);
        tick(); // e1
        check("z_tc_e1", tc2, 0);
        tick(); // e2
        check("z_tc_e2", tc2, 1); check("z_done_e2", done2, 1);

        // START while busy is ignored: PRESET=10 up, TC at e7
        preset1 = 4'd10; dir1 = 0; cont1 = 0; start1 = 1;
        tick(); // e0
        start1 = 0;
        tick(); tick(); tick(); // e1..e3
        start1 = 1; preset1 = 4'd2; dir1 = 1;
        tick(); // e4
        start1 = 0;
        check("sb_d", d1, 10); check("sb_dir", dnup1, 0);
        check("sb_busy", busy1, 1); check("sb_tc", tc1, 0);
        tick(); tick(); // e5, e6
        check("sb_tc_e6", tc1, 0);
        tick(); // e7
        check("sb_tc_e7", tc1, 1); check("sb_done_e7", done1, 1);
        tick();

        // STOP mid-COUNT
        preset1 = 4'd0; dir1 = 0; cont1 = 0; start1 = 1;
        tick(); // e0
        start1 = 0;
        tick(); tick(); tick(); // e1..e3
        stop1 = 1;
        tick(); // e4
        stop1 = 0;
        check("sm_busy", busy1, 0); check("sm_cten", cten1_n, 1);
        check("sm_load", load1_n, 1); check("sm_done", done1, 0);
        check("sm_tc", tc1, 0); check("sm_state", st1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sm_idle_tc", tc1, 0);
            check("sm_idle_done", done1, 0);
            check("sm_idle_busy", busy1, 0);
        end

        // STOP together with START in IDLE
        preset1 = 4'd5; start1 = 1; stop1 = 1;
        tick();
        start1 = 0; stop1 = 0;
        check("ss_busy", busy1, 0); check("ss_load", load1_n, 1);
        check("ss_cten", cten1_n, 1); check("ss_state", st1, 0);

        // Reset during COUNT, then a forced RCO_n low is ignored
        preset1 = 4'd9; dir1 = 1; cont1 = 1; start1 = 1;
        tick(); // e0
        start1 = 0;
        tick(); tick(); // e1, e2
        check("rc_dir_pre", dnup1, 1); check("rc_d_pre", d1, 9);
        rst_n = 0;
        tick(); // e3
        rst_n = 1;
        check("rc_state", st1, 0);    check("rc_load", load1_n, 1);
        check("rc_cten", cten1_n, 1); check("rc_dnup", dnup1, 0);
        check("rc_d", d1, 0);         check("rc_busy", busy1, 0);
        check("rc_tc", tc1, 0);       check("rc_done", done1, 0);
        check("rc_err", err1, 0);
        rco1_force = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rc_ign_busy", busy1, 0);
            check("rc_ign_tc", tc1, 0);
            check("rc_ign_done", done1, 0);
        end
        rco1_force = 0;

        // Corrupted Q bit: ERROR set and sticky when the checker is built in
        q1_flip = 4'b0100;
        preset1 = 4'd4; dir1 = 0; cont1 = 0; start1 = 1;
        tick(); // e0
        start1 = 0;
        tick(); tick(); tick(); // e1..e3
        check("er_set", err1, EXP_ERR);
        q1_flip = '0;
        stop1 = 1;
        tick();
        stop1 = 0;
        preset1 = 4'd14; start1 = 1;
        tick(); // e0
        start1 = 0;
        tick(); tick(); // e1, e2
        check("er_clean_tc_e2", tc1, 0);
        tick(); // e3
        check("er_clean_tc_e3", tc1, 1);
        check("er_sticky", err1, EXP_ERR);
        rst_n = 0;
        tick();
        rst_n = 1;
        check("er_clear", err1, 0);
        tick();
        check("er_clear2", err1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
